// File: rtl/spi_host_master.sv
// SPI mode-0 initiator: byte stream in, framed SPI out, one rx strobe per byte (8th falling SCLK edge).
// Latency: cs/mosi one cycle after acceptance, rx_valid 1+16*CLK_DIV cycles after; tx_ready low while a byte, HOLD or GAP is in flight.
module spi_host_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, PAUSE, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [6:0] tx_sr, tx_sr_nxt;
  logic [6:0] rx_sr, rx_sr_nxt;
  logic       last_q, last_nxt;
  logic       sclk_nxt, mosi_nxt, cs_nxt, rx_valid_nxt;
  logic [7:0] rx_data_nxt;
  logic       accept, cnt_done;

  assign tx_ready = !reset && (state == IDLE || state == PAUSE);
  assign busy     = (state != IDLE);
  assign accept   = tx_valid && tx_ready;
  assign cnt_done = (cnt == DIV_LAST);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_nxt      = bit_cnt;
    tx_sr_nxt    = tx_sr;
    rx_sr_nxt    = rx_sr;
    last_nxt     = last_q;
    sclk_nxt     = spi_sclk;
    mosi_nxt     = spi_mosi;
    cs_nxt       = spi_cs;
    rx_valid_nxt = 1'b0;
    rx_data_nxt  = rx_data;
    case (state)
      IDLE, PAUSE: begin
        if (accept) begin
          state_nxt = LEAD;
          cnt_nxt   = '0;
          bit_nxt   = '0;
          tx_sr_nxt = tx_data[6:0];
          last_nxt  = tx_last;
          cs_nxt    = 1'b0;
          mosi_nxt  = tx_data[7];
        end
      end
      LEAD: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt_done) begin
          cnt_nxt   = '0;
          sclk_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt_done) begin
          cnt_nxt = '0;
          if (spi_sclk) begin
            // Last cycle of the high half: sample miso, then drop sclk.
            sclk_nxt  = 1'b0;
            rx_sr_nxt = {rx_sr[5:0], spi_miso};
            if (bit_cnt == 3'd7) begin
              rx_valid_nxt = 1'b1;
              rx_data_nxt  = {rx_sr, spi_miso};
              state_nxt    = last_q ? HOLD : PAUSE;
            end else begin
              bit_nxt   = bit_cnt + 3'd1;
              mosi_nxt  = tx_sr[6];
              tx_sr_nxt = {tx_sr[5:0], 1'b0};
            end
          end else begin
            sclk_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt_done) begin
          cnt_nxt   = '0;
          cs_nxt    = 1'b1;
          mosi_nxt  = 1'b0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt_done) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      last_q   <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs   <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_nxt;
      tx_sr    <= tx_sr_nxt;
      rx_sr    <= rx_sr_nxt;
      last_q   <= last_nxt;
      spi_sclk <= sclk_nxt;
      spi_mosi <= mosi_nxt;
      spi_cs   <= cs_nxt;
      rx_valid <= rx_valid_nxt;
      rx_data  <= rx_data_nxt;
    end
  end

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: three instances (CLK_DIV 4, 2, 7), each with an SPI target model and protocol monitor.
module tb_spi_host_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic       rst[3], tx_valid[3], tx_last[3], tx_ready[3], rx_valid[3], busy[3];
  logic       sclk[3], mosi[3], miso[3], cs[3];
  logic [7:0] tx_data[3], rx_data[3];

  // Target reply bytes are consumed in order, one per SPI byte the target sees start.
  logic [7:0] tgt_mem[3][256];
  int         tgt_idx[3];
  int         acc_n[3], rxv_n[3], mo_n[3], rise_n[3], csf_n[3], csr_n[3], csf_c[3], csr_c[3];
  int         acc_c[3][256], rxv_c[3][256];
  logic [7:0] rxv_d[3][256], mo_d[3][256];
  logic [7:0] sw_tx[3][64];

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 2 : 7);

    spi_host_master #(.CLK_DIV(D)) dut (
      .clk(clk), .reset(rst[g]),
      .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]), .tx_data(tx_data[g]), .tx_last(tx_last[g]),
      .rx_valid(rx_valid[g]), .rx_data(rx_data[g]), .busy(busy[g]),
      .spi_sclk(sclk[g]), .spi_mosi(mosi[g]), .spi_miso(miso[g]), .spi_cs(cs[g])
    );

    logic       p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, armed = 1'b0;
    logic [7:0] sr = 8'h00, cap = 8'h00;
    int         nb = 0, last_chg = 0;

    initial miso[g] = 1'b0;

    // Target + monitor, evaluated mid-cycle so DUT outputs are settled.
    always @(negedge clk) begin
      n_vec++;
      if (cs[g] && sclk[g]) begin
        n_err++;
        $display("FAIL sclk_idle inst=%0d cyc=%0d sclk=%b while cs high, required 0", g, cyc, sclk[g]);
      end
      if (!cs[g] && p_sclk && sclk[g]) begin
        n_vec++;
        if (mosi[g] !== p_mosi) begin
          n_err++;
          $display("FAIL mosi_stable inst=%0d cyc=%0d mosi=%b required %b", g, cyc, mosi[g], p_mosi);
        end
      end
      if (p_cs && !cs[g]) begin
        csf_n[g]++; csf_c[g] = cyc;
        sr = tgt_mem[g][tgt_idx[g] & 255]; tgt_idx[g]++; miso[g] = sr[7]; armed = 1'b1;
        nb = 0; last_chg = cyc;
      end else if (!p_cs && cs[g]) begin
        csr_n[g]++; csr_c[g] = cyc;
        if (armed) tgt_idx[g]--;
        armed = 1'b0; nb = 0;
      end
      if (!cs[g] && !p_sclk && sclk[g]) begin
        if (nb > 0) begin
          n_vec++;
          if (cyc - last_chg != D) begin
            n_err++;
            $display("FAIL low_half inst=%0d cyc=%0d len=%0d required %0d", g, cyc, cyc - last_chg, D);
          end
        end
        cap = {cap[6:0], mosi[g]}; nb++; armed = 1'b0; rise_n[g]++; last_chg = cyc;
      end
      if (!cs[g] && p_sclk && !sclk[g]) begin
        n_vec++;
        if (cyc - last_chg != D) begin
          n_err++;
          $display("FAIL high_half inst=%0d cyc=%0d len=%0d required %0d", g, cyc, cyc - last_chg, D);
        end
        last_chg = cyc;
        if (nb == 8) begin
          mo_d[g][mo_n[g] & 255] = cap; mo_n[g]++; nb = 0;
          sr = tgt_mem[g][tgt_idx[g] & 255]; tgt_idx[g]++; miso[g] = sr[7]; armed = 1'b1;
        end else begin
          sr = {sr[6:0], 1'b0}; miso[g] = sr[7];
        end
      end
      if (rx_valid[g]) begin
        rxv_c[g][rxv_n[g] & 255] = cyc; rxv_d[g][rxv_n[g] & 255] = rx_data[g]; rxv_n[g]++;
      end
      if (tx_valid[g] && tx_ready[g]) begin
        acc_c[g][acc_n[g] & 255] = cyc; acc_n[g]++;
      end
      p_cs = cs[g]; p_sclk = sclk[g]; p_mosi = mosi[g];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int g, input logic [7:0] d, input logic l);
    int waited = 0;
    tx_valid[g] = 1'b1; tx_data[g] = d; tx_last[g] = l;
    while (!tx_ready[g] && waited < 4000) begin
      step();
      waited++;
    end
    n_vec++;
    if (!tx_ready[g]) begin
      n_err++;
      $display("FAIL push_timeout inst=%0d data=%h tx_ready=%b required 1", g, d, tx_ready[g]);
    end
    step();
    tx_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int waited = 0;
    while (busy[g] && waited < 4000) begin
      step();
      waited++;
    end
    n_vec++;
    if (busy[g]) begin
      n_err++;
      $display("FAIL idle_timeout inst=%0d busy=%b required 0", g, busy[g]);
    end
  endtask

  task automatic test_reset();
    logic [13:0] got;
    logic [13:0] exp_rst;
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; tx_valid[g] = 1'b0; tx_data[g] = 8'h00; tx_last[g] = 1'b0;
    end
    step(); step(); step();
    // {cs, sclk, mosi, rx_valid, rx_data, busy, tx_ready}
    exp_rst = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int g = 0; g < 3; g++) begin
      got = {cs[g], sclk[g], mosi[g], rx_valid[g], rx_data[g], busy[g], tx_ready[g]};
      n_vec++;
      if (got !== exp_rst) begin
        n_err++;
        $display("FAIL reset_state inst=%0d got=%h required %h", g, got, exp_rst);
      end
    end
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;
    step();
    for (int g = 0; g < 3; g++) begin
      n_vec++;
      if (tx_ready[g] !== 1'b1) begin
        n_err++;
        $display("FAIL ready_after_reset inst=%0d tx_ready=%b required 1", g, tx_ready[g]);
      end
    end
  endtask

  task automatic test_single();
    int c0, rdy_at, waited;
    int rb = rxv_n[0], mb = mo_n[0], rsb = rise_n[0], cfb = csf_n[0], crb = csr_n[0];
    tgt_mem[0][tgt_idx[0] & 255] = 8'h3C;
    push(0, 8'hA5, 1'b1);
    c0 = acc_c[0][(acc_n[0] - 1) & 255];
    waited = 0;
    while (!tx_ready[0] && waited < 400) begin
      step();
      waited++;
    end
    rdy_at = cyc - c0;
    n_vec++; if (mo_d[0][mb & 255] !== 8'hA5 || mo_n[0] != mb + 1) begin n_err++; $display("FAIL single_mosi byte=%h required a5", mo_d[0][mb & 255]); end
    n_vec++; if (rise_n[0] - rsb != 8) begin n_err++; $display("FAIL single_rises got=%0d required 8", rise_n[0] - rsb); end
    n_vec++; if (rxv_n[0] - rb != 1) begin n_err++; $display("FAIL single_rx_count got=%0d required 1", rxv_n[0] - rb); end
    n_vec++; if (rxv_c[0][rb & 255] - c0 != 65) begin n_err++; $display("FAIL single_rx_time n=%0d required 65", rxv_c[0][rb & 255] - c0); end
    n_vec++; if (rxv_d[0][rb & 255] !== 8'h3C) begin n_err++; $display("FAIL single_rx_data got=%h required 3c", rxv_d[0][rb & 255]); end
    n_vec++; if (csf_n[0] - cfb != 1 || csf_c[0] - c0 != 1) begin n_err++; $display("FAIL single_cs_fall n=%0d required 1", csf_c[0] - c0); end
    n_vec++; if (csr_n[0] - crb != 1 || csr_c[0] - c0 != 69) begin n_err++; $display("FAIL single_cs_rise n=%0d required 69", csr_c[0] - c0); end
    n_vec++; if (rdy_at != 73) begin n_err++; $display("FAIL single_ready_back n=%0d required 73", rdy_at); end
    n_vec++; if (rx_data[0] !== 8'h3C) begin n_err++; $display("FAIL single_rx_hold got=%h required 3c", rx_data[0]); end
  endtask

  task automatic test_burst();
    logic [7:0] exp_rx[3];
    int ab = acc_n[0], rb = rxv_n[0], mb = mo_n[0], rsb = rise_n[0], cfb = csf_n[0], crb = csr_n[0];
    for (int k = 0; k < 3; k++) begin
      exp_rx[k] = 8'($urandom);
      tgt_mem[0][(tgt_idx[0] + k) & 255] = exp_rx[k];
    end
    push(0, 8'h01, 1'b0);
    push(0, 8'h02, 1'b0);
    push(0, 8'h03, 1'b1);
    wait_idle(0);
    n_vec++; if (csf_n[0] - cfb != 1 || csr_n[0] - crb != 1) begin n_err++; $display("FAIL burst_cs_frames falls=%0d rises=%0d required 1 1", csf_n[0] - cfb, csr_n[0] - crb); end
    n_vec++; if (rise_n[0] - rsb != 24) begin n_err++; $display("FAIL burst_rises got=%0d required 24", rise_n[0] - rsb); end
    for (int k = 1; k < 3; k++) begin
      n_vec++;
      if (acc_c[0][(ab + k) & 255] - acc_c[0][(ab + k - 1) & 255] != 65) begin
        n_err++;
        $display("FAIL burst_accept_gap byte=%0d gap=%0d required 65", k, acc_c[0][(ab + k) & 255] - acc_c[0][(ab + k - 1) & 255]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (mo_d[0][(mb + k) & 255] !== 8'(k + 1)) begin n_err++; $display("FAIL burst_mosi byte=%0d got=%h required %h", k, mo_d[0][(mb + k) & 255], 8'(k + 1)); end
      n_vec++; if (rxv_d[0][(rb + k) & 255] !== exp_rx[k]) begin n_err++; $display("FAIL burst_rx byte=%0d got=%h required %h", k, rxv_d[0][(rb + k) & 255], exp_rx[k]); end
    end
  endtask

  task automatic test_pause();
    int bad_cs = 0, bad_sclk = 0, bad_rdy = 0, waited = 0;
    int rb = rxv_n[0], mb = mo_n[0], cfb = csf_n[0], crb = csr_n[0];
    logic [7:0] r0 = 8'($urandom), r1 = 8'($urandom);
    tgt_mem[0][tgt_idx[0] & 255] = r0;
    tgt_mem[0][(tgt_idx[0] + 1) & 255] = r1;
    push(0, 8'h55, 1'b0);
    while (!tx_ready[0] && waited < 400) begin
      step();
      waited++;
    end
    for (int k = 0; k < 100; k++) begin
      if (cs[0] !== 1'b0) bad_cs++;
      if (sclk[0] !== 1'b0) bad_sclk++;
      if (tx_ready[0] !== 1'b1) bad_rdy++;
      step();
    end
    n_vec++; if (bad_cs != 0) begin n_err++; $display("FAIL pause_cs cycles_high=%0d required 0", bad_cs); end
    n_vec++; if (bad_sclk != 0) begin n_err++; $display("FAIL pause_sclk cycles_high=%0d required 0", bad_sclk); end
    n_vec++; if (bad_rdy != 0) begin n_err++; $display("FAIL pause_ready cycles_low=%0d required 0", bad_rdy); end
    push(0, 8'hAA, 1'b1);
    wait_idle(0);
    n_vec++; if (csf_n[0] - cfb != 1 || csr_n[0] - crb != 1) begin n_err++; $display("FAIL pause_frames falls=%0d rises=%0d required 1 1", csf_n[0] - cfb, csr_n[0] - crb); end
    n_vec++; if (mo_d[0][mb & 255] !== 8'h55 || mo_d[0][(mb + 1) & 255] !== 8'hAA) begin n_err++; $display("FAIL pause_mosi got=%h %h required 55 aa", mo_d[0][mb & 255], mo_d[0][(mb + 1) & 255]); end
    n_vec++; if (rxv_d[0][rb & 255] !== r0 || rxv_d[0][(rb + 1) & 255] !== r1) begin n_err++; $display("FAIL pause_rx got=%h %h required %h %h", rxv_d[0][rb & 255], rxv_d[0][(rb + 1) & 255], r0, r1); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] got;
    int c0, waited = 0;
    int rb, mb;
    tgt_mem[0][tgt_idx[0] & 255] = 8'h5A;
    tgt_mem[0][(tgt_idx[0] + 1) & 255] = 8'h81;
    rb = rxv_n[0];
    push(0, 8'h96, 1'b1);
    c0 = acc_c[0][(acc_n[0] - 1) & 255];
    while (cyc < c0 + 30 && waited < 100) begin
      step();
      waited++;
    end
    rst[0] = 1'b1;
    step();
    got = {cs[0], sclk[0], mosi[0], rx_valid[0], busy[0]};
    n_vec++; if (got !== 5'b10000) begin n_err++; $display("FAIL midreset_outputs {cs,sclk,mosi,rx_valid,busy}=%b required 10000", got); end
    step(); step();
    rst[0] = 1'b0;
    step();
    n_vec++; if (rxv_n[0] != rb) begin n_err++; $display("FAIL midreset_no_rx strobes=%0d required 0", rxv_n[0] - rb); end
    mb = mo_n[0];
    push(0, 8'hFF, 1'b1);
    wait_idle(0);
    n_vec++; if (mo_n[0] != mb + 1 || mo_d[0][mb & 255] !== 8'hFF) begin n_err++; $display("FAIL midreset_mosi got=%h required ff", mo_d[0][mb & 255]); end
    n_vec++; if (rxv_n[0] != rb + 1 || rx_data[0] !== 8'h81) begin n_err++; $display("FAIL midreset_rx got=%h required 81", rx_data[0]); end
  endtask

  task automatic test_const();
    tgt_mem[0][tgt_idx[0] & 255] = 8'hFF;
    tgt_mem[0][(tgt_idx[0] + 1) & 255] = 8'h00;
    push(0, 8'h3C, 1'b1);
    wait_idle(0);
    n_vec++; if (rx_data[0] !== 8'hFF) begin n_err++; $display("FAIL const_ones got=%h required ff", rx_data[0]); end
    push(0, 8'hC3, 1'b1);
    wait_idle(0);
    n_vec++; if (rx_data[0] !== 8'h00) begin n_err++; $display("FAIL const_zeros got=%h required 00", rx_data[0]); end
  endtask

  task automatic run_stream(input int g);
    for (int k = 0; k < 64; k++) begin
      push(g, sw_tx[g][k], (k == 63) || ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) step();
    end
    wait_idle(g);
  endtask

  task automatic test_sweep();
    int mb[3], rb[3], tb[3];
    for (int g = 1; g < 3; g++) begin
      mb[g] = mo_n[g]; rb[g] = rxv_n[g]; tb[g] = tgt_idx[g];
      for (int k = 0; k < 64; k++) begin
        sw_tx[g][k] = 8'($urandom);
        tgt_mem[g][(tb[g] + k) & 255] = 8'($urandom);
      end
    end
    fork
      run_stream(1);
      run_stream(2);
    join
    for (int g = 1; g < 3; g++) begin
      n_vec++; if (mo_n[g] - mb[g] != 64 || rxv_n[g] - rb[g] != 64) begin n_err++; $display("FAIL sweep_count inst=%0d mosi=%0d rx=%0d required 64", g, mo_n[g] - mb[g], rxv_n[g] - rb[g]); end
      for (int k = 0; k < 64; k++) begin
        n_vec++;
        if (mo_d[g][(mb[g] + k) & 255] !== sw_tx[g][k]) begin
          n_err++; $display("FAIL sweep_mosi inst=%0d byte=%0d got=%h required %h", g, k, mo_d[g][(mb[g] + k) & 255], sw_tx[g][k]);
        end
        n_vec++;
        if (rxv_d[g][(rb[g] + k) & 255] !== tgt_mem[g][(tb[g] + k) & 255]) begin
          n_err++; $display("FAIL sweep_rx inst=%0d byte=%0d got=%h required %h", g, k, rxv_d[g][(rb[g] + k) & 255], tgt_mem[g][(tb[g] + k) & 255]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_pause();
    test_reset_mid();
    test_const();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d limit reached before the sequence completed", cyc);
    $fatal(1, "watchdog");
  end

endmodule
